// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: control-word layout and result-source encodings.
// Control word is {RegWrite,ALUSrc,MemWrite,ResultSrc,Branch,Jump,PCResultSrc,ALUControl,DexControl}.
package id_ex_stage_pkg;

  localparam int CTRL_W = 16;

  localparam int CTRL_REGWRITE  = 15;
  localparam int CTRL_ALUSRC    = 14;
  localparam int CTRL_MEMWRITE  = 13;
  localparam int CTRL_RES_HI    = 12;
  localparam int CTRL_RES_LO    = 10;
  localparam int CTRL_BRANCH    = 9;
  localparam int CTRL_JUMP      = 8;
  localparam int CTRL_PCRES     = 7;
  localparam int CTRL_ALU_HI    = 6;
  localparam int CTRL_ALU_LO    = 3;
  localparam int CTRL_DEX_HI    = 2;
  localparam int CTRL_DEX_LO    = 0;

  localparam logic [2:0] RESULT_LOAD = 3'b001;

  function automatic logic [2:0] ctrl_result_src(
    input logic [CTRL_W-1:0] ctrl
  );
    return ctrl[CTRL_RES_HI:CTRL_RES_LO];
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the EX slot and the decode slot.
// Purely combinational; a redirect suppresses the stall request.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RIDX = 5
) (
  input  logic              ValidE,
  input  logic [CTRL_W-1:0] CtrlE,
  input  logic [RIDX-1:0]   RdE,
  input  logic              ValidD,
  input  logic [RIDX-1:0]   Rs1D,
  input  logic [RIDX-1:0]   Rs2D,
  input  logic              FlushE,
  output logic              LoadUse,
  output logic              StallF,
  output logic              StallD
);

  logic ld_e;
  logic hit;

  assign ld_e = ValidE
              & (ctrl_result_src(CtrlE) == RESULT_LOAD)
              & (RdE != '0);
  assign hit  = (RdE == Rs1D) | (RdE == Rs2D);

  assign LoadUse = ld_e & ValidD & hit;
  assign StallF  = LoadUse & ~FlushE;
  assign StallD  = LoadUse & ~FlushE;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional bubble counter output enabled by IDEX_BUBBLE_CNT_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic              ValidD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [RIDX-1:0]   Rs1D,
  input  logic [RIDX-1:0]   Rs2D,
  input  logic [RIDX-1:0]   RdD,
  input  logic              FlushE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [RIDX-1:0]   Rs1E,
  output logic [RIDX-1:0]   Rs2E,
  output logic [RIDX-1:0]   RdE,
`ifdef IDEX_BUBBLE_CNT_EN
  output logic [31:0]       BubbleCnt,
`endif
  output logic              StallF,
  output logic              StallD
);

  logic load_use;
  logic bubble;

  hazard_detect #(
    .RIDX(RIDX)
  ) u_hazard (
    .ValidE (ValidE),
    .CtrlE  (CtrlE),
    .RdE    (RdE),
    .ValidD (ValidD),
    .Rs1D   (Rs1D),
    .Rs2D   (Rs2D),
    .FlushE (FlushE),
    .LoadUse(load_use),
    .StallF (StallF),
    .StallD (StallD)
  );

  assign bubble = FlushE | load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CtrlE    <= '0;
      ValidE   <= 1'b0;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else if (bubble) begin
      CtrlE    <= '0;
      ValidE   <= 1'b0;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else begin
      // an invalid slot must never carry side-effecting controls
      CtrlE    <= ValidD ? CtrlD : '0;
      ValidE   <= ValidD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      PCE      <= PCD;
      ImmExtE  <= ImmExtD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BubbleCnt <= '0;
    end else if (bubble && (BubbleCnt != 32'hFFFF_FFFF)) begin
      BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage.
// Bubble-counter checks compile in when IDEX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] CtrlD;
  logic        ValidD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        FlushE;
  logic [15:0] CtrlE;
  logic        ValidE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        StallF, StallD;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] BubbleCnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .CtrlD(CtrlD), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .FlushE(FlushE),
    .CtrlE(CtrlE), .ValidE(ValidE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
`ifdef IDEX_BUBBLE_CNT_EN
    .BubbleCnt(BubbleCnt),
`endif
    .StallF(StallF), .StallD(StallD)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [15:0] c, input logic v,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] pc,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic f);
    CtrlD    = c;
    ValidD   = v;
    RD1D     = r1;
    RD2D     = r2;
    PCD      = pc;
    ImmExtD  = r1 ^ 32'h0F0F_0000;
    PCPlus4D = pc + 32'd4;
    Rs1D     = s1;
    Rs2D     = s2;
    RdD      = d;
    FlushE   = f;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_e(input string tag, input logic [15:0] c,
                       input logic v, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] pc,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    chk({tag, ".ctrl"}, CtrlE, c);
    chk({tag, ".valid"}, ValidE, v);
    chk({tag, ".rd1"}, RD1E, r1);
    chk({tag, ".rd2"}, RD2E, r2);
    chk({tag, ".pc"}, PCE, pc);
    chk({tag, ".rs1"}, Rs1E, s1);
    chk({tag, ".rs2"}, Rs2E, s2);
    chk({tag, ".rd"}, RdE, d);
  endtask

  localparam logic [15:0] LW  = 16'h8400;
  localparam logic [15:0] ADD = 16'h8018;

  initial begin
    rst_n = 1'b0;
    drv(16'hFFFF, 1'b1, 32'h1, 32'h2, 32'h3, 5'd5, 5'd5, 5'd5, 1'b0);
    #2;
    chk("rst.valid", ValidE, 1'b0);
    chk("rst.ctrl", CtrlE, 16'h0);
    chk("rst.rd", RdE, 5'd0);
    chk("rst.stall", StallF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // plain pass-through
    drv(16'hA5C3, 1'b1, 32'h1234_5678, 32'hCAFE_0001,
        32'h0000_1000, 5'd1, 5'd2, 5'd7, 1'b0);
    #1;
    chk("pass.stallF", StallF, 1'b0);
    edge1();
    chk_e("pass", 16'hA5C3, 1'b1, 32'h1234_5678, 32'hCAFE_0001,
          32'h0000_1000, 5'd1, 5'd2, 5'd7);
    chk("pass.imm", ImmExtE, 32'h1D3B_5678);
    chk("pass.pc4", PCPlus4E, 32'h0000_1004);

    // invalid slot: EX holds a load to x7 but D is invalid, no stall
    @(negedge clk);
    drv(16'hFFFF, 1'b0, 32'h11, 32'h22, 32'h1004,
        5'd7, 5'd7, 5'd3, 1'b0);
    #1;
    chk("inv.stallF", StallF, 1'b0);
    edge1();
    chk("inv.ctrl", CtrlE, 16'h0);
    chk("inv.valid", ValidE, 1'b0);
    chk("inv.rd", RdE, 5'd3);

    // lw x5 into EX
    @(negedge clk);
    drv(LW, 1'b1, 32'hA0, 32'hB0, 32'h2000, 5'd1, 5'd0, 5'd5, 1'b0);
    #1;
    chk("lw.stallF", StallF, 1'b0);
    edge1();
    chk("lw.ctrl", CtrlE, LW);
    chk("lw.rd", RdE, 5'd5);

    // consumer of x5 via rs2: one stall cycle then capture
    @(negedge clk);
    drv(ADD, 1'b1, 32'h5555_AAAA, 32'h0BAD_F00D, 32'h2004,
        5'd6, 5'd5, 5'd9, 1'b0);
    #1;
    chk("lu.stallF", StallF, 1'b1);
    chk("lu.stallD", StallD, 1'b1);
    edge1();
    chk_e("lu.bub", 16'h0, 1'b0, 32'h0, 32'h0, 32'h0,
          5'd0, 5'd0, 5'd0);
    chk("lu.stall2", StallF, 1'b0);
    edge1();
    chk_e("lu.held", ADD, 1'b1, 32'h5555_AAAA, 32'h0BAD_F00D,
          32'h2004, 5'd6, 5'd5, 5'd9);

    // load to x0 never stalls
    @(negedge clk);
    drv(LW, 1'b1, 32'hC0, 32'hD0, 32'h3000, 5'd2, 5'd2, 5'd0, 1'b0);
    edge1();
    chk("lx0.ctrl", CtrlE, LW);
    @(negedge clk);
    drv(ADD, 1'b1, 32'h77, 32'h88, 32'h3004, 5'd0, 5'd0, 5'd4, 1'b0);
    #1;
    chk("lx0.stallF", StallF, 1'b0);
    edge1();
    chk_e("lx0.cap", ADD, 1'b1, 32'h77, 32'h88, 32'h3004,
          5'd0, 5'd0, 5'd4);

    // flush coincident with load-use: redirect wins
    @(negedge clk);
    drv(LW, 1'b1, 32'hE0, 32'hF0, 32'h4000, 5'd1, 5'd1, 5'd5, 1'b0);
    edge1();
    chk("fl.ld", CtrlE, LW);
    @(negedge clk);
    drv(ADD, 1'b1, 32'h99, 32'hAA, 32'h4004, 5'd5, 5'd3, 5'd8, 1'b1);
    #1;
    chk("fl.stallF", StallF, 1'b0);
    chk("fl.stallD", StallD, 1'b0);
    edge1();
    chk_e("fl.bub", 16'h0, 1'b0, 32'h0, 32'h0, 32'h0,
          5'd0, 5'd0, 5'd0);

    // two plain flushes
    @(negedge clk);
    drv(ADD, 1'b1, 32'h1, 32'h2, 32'h5000, 5'd1, 5'd2, 5'd3, 1'b1);
    edge1();
    chk("fl2.valid", ValidE, 1'b0);
    edge1();
    chk("fl3.ctrl", CtrlE, 16'h0);
`ifdef IDEX_BUBBLE_CNT_EN
    chk("cnt", BubbleCnt, 32'd4);
`endif

    // mid-run reset clears EX without a clock edge
    @(negedge clk);
    drv(LW, 1'b1, 32'h1111, 32'h2222, 32'h6000, 5'd1, 5'd2, 5'd5, 1'b0);
    edge1();
    chk("mr.pre", ValidE, 1'b1);
    @(negedge clk);
    drv(ADD, 1'b1, 32'h3333, 32'h4444, 32'h6004, 5'd5, 5'd5, 5'd6, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr.valid", ValidE, 1'b0);
    chk("mr.ctrl", CtrlE, 16'h0);
    chk("mr.rd", RdE, 5'd0);
    chk("mr.stall", StallF, 1'b0);
`ifdef IDEX_BUBBLE_CNT_EN
    chk("mr.cnt", BubbleCnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr.nostall", StallD, 1'b0);
    edge1();
    chk_e("mr.cap", ADD, 1'b1, 32'h3333, 32'h4444, 32'h6004,
          5'd5, 5'd5, 5'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
